// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving
// datapath selects, write strobes and ALU opcode; MEM stalls on mem_ready.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       pc_we,
    output logic [1:0] pcsrc,
    output logic       ir_we,
    output logic       regdst,
    output logic       alusrc,
    output logic       ext_op,
    output logic [2:0] aluop,
    output logic       mem_req,
    output logic       mem_we,
    output logic       memtoreg,
    output logic       reg_we,
    output logic       insn_done,
    output logic       illegal
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic w_addu, w_subu, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_legal;

    logic       w_ex_alusrc;
    logic       w_ex_ext_op;
    logic [2:0] w_ex_aluop;

    logic       w_pc_we;
    logic [1:0] w_pcsrc;
    logic       w_ir_we;
    logic       w_regdst;
    logic       w_alusrc;
    logic       w_ext_op;
    logic [2:0] w_aluop;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_memtoreg;
    logic       w_reg_we;
    logic       w_insn_done;
    logic       w_illegal;

    assign w_addu  = (opcode == OP_RTYPE) && (funct == FN_ADDU);
    assign w_subu  = (opcode == OP_RTYPE) && (funct == FN_SUBU);
    assign w_ori   = (opcode == OP_ORI);
    assign w_lui   = (opcode == OP_LUI);
    assign w_lw    = (opcode == OP_LW);
    assign w_sw    = (opcode == OP_SW);
    assign w_beq   = (opcode == OP_BEQ);
    assign w_j     = (opcode == OP_J);
    assign w_legal = w_addu | w_subu | w_ori | w_lui | w_lw | w_sw | w_beq | w_j;

    // ALU setup chosen in EXEC and held unchanged through MEM and WB
    always_comb begin
        w_ex_alusrc = 1'b0;
        w_ex_ext_op = 1'b0;
        w_ex_aluop  = ALU_ADD;
        if (w_subu) begin
            w_ex_aluop = ALU_SUB;
        end else if (w_ori) begin
            w_ex_alusrc = 1'b1;
            w_ex_aluop  = ALU_OR;
        end else if (w_lui) begin
            w_ex_alusrc = 1'b1;
            w_ex_aluop  = ALU_LUI;
        end else if (w_lw || w_sw) begin
            w_ex_alusrc = 1'b1;
            w_ex_ext_op = 1'b1;
        end else if (w_beq) begin
            w_ex_ext_op = 1'b1;
            w_ex_aluop  = ALU_SUB;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        w_pc_we      = 1'b0;
        w_pcsrc      = 2'b00;
        w_ir_we      = 1'b0;
        w_regdst     = 1'b0;
        w_alusrc     = 1'b0;
        w_ext_op     = 1'b0;
        w_aluop      = ALU_ADD;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_memtoreg   = 1'b0;
        w_reg_we     = 1'b0;
        w_insn_done  = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_we      = 1'b1;
                w_pc_we      = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                if (w_j) begin
                    w_pc_we     = 1'b1;
                    w_pcsrc     = 2'b10;
                    w_insn_done = 1'b1;
                end else if (!w_legal) begin
                    w_illegal   = 1'b1;
                    w_insn_done = 1'b1;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alusrc = w_ex_alusrc;
                w_ext_op = w_ex_ext_op;
                w_aluop  = w_ex_aluop;
                if (w_beq) begin
                    w_pcsrc     = 2'b01;
                    w_pc_we     = zero;
                    w_insn_done = 1'b1;
                end else if (w_lw || w_sw) begin
                    w_next_state = S_MEM;
                end else if (w_legal) begin
                    w_next_state = S_WB;
                end
            end
            // Handshake: mem_req/mem_we stay constant while in MEM; the access
            // completes on the edge where mem_ready=1, which also leaves MEM.
            S_MEM: begin
                w_alusrc = w_ex_alusrc;
                w_ext_op = w_ex_ext_op;
                w_aluop  = w_ex_aluop;
                if (w_lw || w_sw) begin
                    w_mem_req = 1'b1;
                    w_mem_we  = w_sw;
                    if (!mem_ready) begin
                        w_next_state = S_MEM;
                    end else if (w_sw) begin
                        w_insn_done = 1'b1;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                w_alusrc    = w_ex_alusrc;
                w_ext_op    = w_ex_ext_op;
                w_aluop     = w_ex_aluop;
                w_reg_we    = 1'b1;
                w_insn_done = 1'b1;
                w_regdst    = w_addu | w_subu;
                w_memtoreg  = w_lw;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Reset gates every strobe so an abandoned instruction issues nothing
    assign state     = r_state;
    assign pc_we     = ~reset & w_pc_we;
    assign pcsrc     = reset ? 2'b00 : w_pcsrc;
    assign ir_we     = ~reset & w_ir_we;
    assign regdst    = ~reset & w_regdst;
    assign alusrc    = ~reset & w_alusrc;
    assign ext_op    = ~reset & w_ext_op;
    assign aluop     = reset ? ALU_ADD : w_aluop;
    assign mem_req   = ~reset & w_mem_req;
    assign mem_we    = ~reset & w_mem_we;
    assign memtoreg  = ~reset & w_memtoreg;
    assign reg_we    = ~reset & w_reg_we;
    assign insn_done = ~reset & w_insn_done;
    assign illegal   = ~reset & w_illegal;

endmodule
